// File: rtl/bf_uart_pkg.sv
// Shared UART receive constants and deframer state encoding.
// Pure declarations: no latency, no flow control.
package bf_uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 12;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

   // State encoding kept as plain constants so older tools and netlists can read it.
   typedef logic [2:0] rx_state_t;
   localparam rx_state_t ST_IDLE  = 3'd0;
   localparam rx_state_t ST_START = 3'd1;
   localparam rx_state_t ST_DATA  = 3'd2;
   localparam rx_state_t ST_STOP  = 3'd3;
   localparam rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/bf_byte_fifo.sv
// Circular byte FIFO with a separate occupancy counter and a push-accepted indication.
// Head is a combinational read (0-cycle); a push when full is only accepted if a pop frees the slot.
module bf_byte_fifo #(
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int WIDTH           = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     push_ok,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [FIFO_ADDR_WIDTH:0] count,
   output logic                     full
);

   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

   logic [WIDTH-1:0]           mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic                       pop_ok;

   assign full    = (count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         // Cleared so the head reads 0x00 straight out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bf_uart_rx_buffer.sv
// 8N1 UART deframer feeding a byte FIFO with sticky overflow/framing flags.
// Byte visible 1 cycle after the stop sample; valid/ready pop, bytes dropped (overflow) when full.
module bf_uart_rx_buffer
   import bf_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   input  logic                      clear_flags,
   input  logic                      data_ready,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      data_valid,
   output logic [FIFO_ADDR_WIDTH:0]  fifo_count,
   output logic                      overflow,
   output logic                      frame_error
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

   rx_state_t  state;
   logic [CW-1:0] clk_cnt;
   logic [2:0] bit_idx;
   uart_byte_t shreg;

   logic stop_sample;
   logic push;
   logic push_ok;
   logic pop;
   logic fifo_full;
   logic ovf_set;
   logic fe_set;

   assign stop_sample = (state == ST_STOP) && (clk_cnt == BIT_LAST);
   assign push        = stop_sample && rx;
   assign fe_set      = stop_sample && !rx;
   assign ovf_set     = push && fifo_full && !push_ok;
   assign data_valid  = (fifo_count != '0);
   assign pop         = data_valid && data_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rx) begin
                  state   <= ST_START;
                  clk_cnt <= '0;
               end
            end
            ST_START: begin
               // Mid-bit check rejects low glitches shorter than half a bit.
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx, shreg[UART_DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  state   <= rx ? ST_IDLE : ST_BREAK;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               // A held-low line must return high before another start is accepted.
               if (rx) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
         if (fe_set) begin
            frame_error <= 1'b1;
         end else if (clear_flags) begin
            frame_error <= 1'b0;
         end
      end
   end

   bf_byte_fifo #(
      .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH),
      .WIDTH           (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shreg),
      .push_ok   (push_ok),
      .pop       (pop),
      .head      (data_out),
      .count     (fifo_count),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_bf_uart_rx_buffer.sv
// Bench for bf_uart_rx_buffer: directed vector table, hand-written corner sequences and random frames.
module tb_bf_uart_rx_buffer;

   localparam int C     = 12;
   localparam int H     = C / 2;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       clear_flags = 1'b0;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       frame_error;

   always #5 clk = ~clk;

   bf_uart_rx_buffer #(
      .CLKS_PER_BIT    (C),
      .FIFO_ADDR_WIDTH (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .clear_flags (clear_flags),
      .data_ready  (data_ready),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .frame_error (frame_error)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: byte queue plus sticky flags.
   byte unsigned q[$];
   bit m_ovf = 1'b0;
   bit m_fe  = 1'b0;
   bit chk_en = 1'b0;

   bit rst_v = 1'b0;
   bit clr_v = 1'b0;
   bit ready_v = 1'b0;
   bit ready_rnd = 1'b0;
   bit pop_on_stop = 1'b0;
   int ready_div = 8;

   typedef struct {
      bit         is_pop;
      logic [7:0] data;
      int         gap;
      int         exp_count;
      logic [7:0] exp_head;
      logic [7:0] exp_pop;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare outputs, drive inputs for the next edge, advance the model across that edge.
   task automatic tick(input logic rx_val, input bit stop_edge, input logic [7:0] frame_byte);
      bit rdy, full, pop, set_o, set_f;
      if (chk_en) begin
         check("data_valid", data_valid, q.size() != 0);
         check("fifo_count", fifo_count, q.size());
         if (q.size() != 0) check("data_out", data_out, q[0]);
         check("overflow", overflow, m_ovf);
         check("frame_error", frame_error, m_fe);
      end
      if (ready_rnd) rdy = ($urandom_range(ready_div - 1) == 0);
      else           rdy = ready_v || (stop_edge && pop_on_stop);
      rx = rx_val;
      reset = rst_v;
      clear_flags = clr_v;
      data_ready = rdy;
      if (rst_v) begin
         q.delete();
         m_ovf = 1'b0;
         m_fe  = 1'b0;
      end else begin
         full  = (q.size() == DEPTH);
         pop   = rdy && (q.size() != 0);
         set_o = stop_edge && rx_val && full && !pop;
         set_f = stop_edge && !rx_val;
         if (pop) void'(q.pop_front());
         if (stop_edge && rx_val && !set_o) q.push_back(frame_byte);
         m_ovf = set_o ? 1'b1 : (clr_v ? 1'b0 : m_ovf);
         m_fe  = set_f ? 1'b1 : (clr_v ? 1'b0 : m_fe);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b1, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_val);
      for (int j = 0; j < 10 * C; j++) begin
         int   bp;
         logic v;
         bp = j / C;
         if (bp == 0)      v = 1'b0;
         else if (bp <= 8) v = b[bp-1];
         else              v = stop_val;
         tick(v, j == H + 9 * C, b);
      end
   endtask

   task automatic pop_one(input string name, input logic [7:0] exp);
      logic [7:0] got;
      got = data_out;
      ready_v = 1'b1;
      tick(1'b1, 1'b0, 8'h00);
      ready_v = 1'b0;
      check(name, got, exp);
   endtask

   task automatic do_reset();
      rst_v = 1'b1;
      idle(2);
      rst_v = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      check("reset data_valid", data_valid, 0);
      check("reset fifo_count", fifo_count, 0);
      check("reset overflow", overflow, 0);
      check("reset frame_error", frame_error, 0);
      check("reset data_out", data_out, 8'h00);
      chk_en = 1'b1;

      tbl[0] = '{1'b0, 8'h41, 1, 1, 8'h41, 8'h00};
      tbl[1] = '{1'b1, 8'h00, 0, 0, 8'h00, 8'h41};
      tbl[2] = '{1'b0, 8'h00, 0, 1, 8'h00, 8'h00};
      tbl[3] = '{1'b0, 8'hFF, 0, 2, 8'h00, 8'h00};
      tbl[4] = '{1'b0, 8'hA5, 1, 3, 8'h00, 8'h00};
      tbl[5] = '{1'b1, 8'h00, 0, 2, 8'hFF, 8'h00};
      tbl[6] = '{1'b1, 8'h00, 0, 1, 8'hA5, 8'hFF};
      tbl[7] = '{1'b1, 8'h00, 0, 0, 8'h00, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].is_pop) pop_one("vec pop value", tbl[i].exp_pop);
         else send_frame(tbl[i].data, 1'b1);
         idle(tbl[i].gap);
         check("vec count", fifo_count, tbl[i].exp_count);
         check("vec valid", data_valid, tbl[i].exp_count != 0);
         if (tbl[i].exp_count != 0) check("vec head", data_out, tbl[i].exp_head);
         check("vec frame_error", frame_error, 0);
      end

      // Overflow, then drain and refill across the pointer wrap.
      for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
      idle(2);
      check("ovf count", fifo_count, 16);
      check("ovf flag", overflow, 1);
      for (int i = 1; i <= 16; i++) pop_one("ovf drain", 8'(i));
      check("drained count", fifo_count, 0);
      send_frame(8'hB1, 1'b1);
      send_frame(8'hB2, 1'b1);
      send_frame(8'hB3, 1'b1);
      idle(1);
      pop_one("wrap pop0", 8'hB1);
      pop_one("wrap pop1", 8'hB2);
      pop_one("wrap pop2", 8'hB3);
      clr_v = 1'b1;
      idle(1);
      clr_v = 1'b0;
      check("ovf cleared", overflow, 0);

      // Full FIFO with a pop on the stop-sample cycle.
      do_reset();
      for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
      idle(1);
      check("full count", fifo_count, 16);
      pop_on_stop = 1'b1;
      send_frame(8'h77, 1'b1);
      pop_on_stop = 1'b0;
      idle(1);
      check("full+pop count", fifo_count, 16);
      check("full+pop overflow", overflow, 0);
      for (int i = 1; i < 16; i++) pop_one("full+pop drain", 8'(8'h20 + i));
      pop_one("full+pop last", 8'h77);

      // Line held low for 20 bit times; flag cleared mid-hold must stay clear.
      for (int j = 0; j < 20 * C; j++) begin
         if (j == H + 9 * C + 3) check("break fe set", frame_error, 1);
         clr_v = (j == H + 9 * C + 5);
         tick(1'b0, j == H + 9 * C, 8'h00);
      end
      clr_v = 1'b0;
      idle(2);
      check("break single fe", frame_error, 0);
      check("break no push", fifo_count, 0);
      send_frame(8'h12, 1'b0);
      idle(2);
      check("bad stop fe", frame_error, 1);
      check("bad stop no push", fifo_count, 0);
      send_frame(8'h5A, 1'b1);
      idle(1);
      check("after fe head", data_out, 8'h5A);
      clr_v = 1'b1;
      idle(1);
      clr_v = 1'b0;
      check("fe cleared", frame_error, 0);
      pop_one("after fe pop", 8'h5A);

      // Short glitch must not start a frame.
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      idle(10 * C);
      check("glitch no push", fifo_count, 0);

      // Reset during data bit 4.
      send_frame(8'h99, 1'b1);
      for (int j = 0; j < 5 * C + 3; j++) begin
         int bp;
         logic [7:0] b;
         b = 8'h3C;
         bp = j / C;
         tick((bp == 0) ? 1'b0 : b[bp-1], 1'b0, 8'h00);
      end
      rst_v = 1'b1;
      idle(1);
      rst_v = 1'b0;
      idle(2 * C);
      check("midreset count", fifo_count, 0);
      check("midreset data_out", data_out, 8'h00);
      send_frame(8'h3C, 1'b1);
      idle(1);
      check("midreset next head", data_out, 8'h3C);
      check("midreset next count", fifo_count, 1);

      // Random frames against the model: slow consumer first, then fast.
      do_reset();
      ready_rnd = 1'b1;
      for (int f = 0; f < 60; f++) begin
         logic [7:0] b;
         bit good;
         ready_div = (f < 30) ? 400 : 6;
         b = 8'($urandom);
         good = ($urandom_range(9) != 0);
         send_frame(b, good);
         idle($urandom_range(15) + (good ? 0 : 1));
         if ($urandom_range(7) == 0) begin
            clr_v = 1'b1;
            idle(1);
            clr_v = 1'b0;
         end
      end
      ready_rnd = 1'b0;
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
